// File: rtl/bop_pkg.sv
// bop_pkg: shared constants and types for the best-offset prefetcher subsystem
package bop_pkg;
    localparam int DELAYQSIZE = 15;
    localparam int DELAY      = 60;
    localparam int TIME_BITS  = 12;
    localparam int LOGLINE    = 6;
    localparam int NOFFSETS   = 46;
    localparam int DQ_WIDTH   = 64;

    typedef logic [TIME_BITS-1:0] bop_ts_t;

    typedef struct packed {
        logic [DQ_WIDTH-1:0] data;
        bop_ts_t             ts;
        logic                matured;
    } bop_dq_entry_t;
endpackage

// File: rtl/bop_delay_queue.sv
// bop_delay_queue: timed circular FIFO releasing each tag DELAY cycles after push
module bop_delay_queue #(
    parameter int WIDTH     = bop_pkg::DQ_WIDTH,
    parameter int DEPTH     = bop_pkg::DELAYQSIZE,
    parameter int DELAY     = bop_pkg::DELAY,
    parameter int TIME_BITS = bop_pkg::TIME_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cq_enq,
    input  logic [WIDTH-1:0] cq_in,
    input  logic             cq_deq,
    output logic [WIDTH-1:0] cq_out,
    output logic             cq_ready,
    output logic             cq_empty,
    output logic             cq_full,
    output logic [15:0]      cq_overflow_cnt
);
    import bop_pkg::*;

    typedef logic [TIME_BITS-1:0] ts_t;
    typedef struct packed {
        logic [WIDTH-1:0] data;
        ts_t              ts;
        logic             matured;
    } entry_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam ts_t DLY = ts_t'(DELAY);

    entry_t           ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    ts_t              now_q;
    logic [15:0]      ovf_q;
    ts_t              age;
    logic             pop;
    logic             drop;

    assign cq_empty        = count_q == '0;
    assign cq_full         = count_q == FULL_CNT;
    assign cq_overflow_cnt = ovf_q;

    // head readiness from registered state; a full push without a pop drops the head
    always_comb begin
        age      = now_q - ent_q[head_q].ts;
        cq_ready = (count_q != '0) && (ent_q[head_q].matured || age >= DLY);
        cq_out   = cq_ready ? ent_q[head_q].data : '0;
        pop      = cq_deq && cq_ready;
        drop     = cq_enq && cq_full && !pop;
    end

    // timestamp, sticky maturity, pointers, occupancy and overflow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            now_q   <= '0;
            ovf_q   <= '0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            now_q <= now_q + 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (vld_q[i] && ts_t'(now_q - ent_q[i].ts) >= DLY) ent_q[i].matured <= 1'b1;
            if (pop || drop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q == LAST ? '0 : head_q + 1'b1;
            end
            if (cq_enq) begin
                ent_q[tail_q] <= '{data: cq_in, ts: now_q, matured: 1'b0};
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q == LAST ? '0 : tail_q + 1'b1;
            end
            if (cq_enq && !pop && !cq_full) count_q <= count_q + 1'b1;
            else if (pop && !cq_enq) count_q <= count_q - 1'b1;
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_bop_delay_queue.sv
// tb_bop_delay_queue: randomized scoreboard bench against a push-cycle based queue model
module tb_bop_delay_queue;
    localparam int D  = 15;
    localparam int DL = 60;

    logic        clk = 1'b0;
    logic        rst, cq_enq, cq_deq;
    logic [63:0] cq_in, cq_out;
    logic        cq_ready, cq_empty, cq_full;
    logic [15:0] cq_overflow_cnt;

    always #5 clk = ~clk;

    bop_delay_queue dut (
        .clk(clk), .rst(rst), .cq_enq(cq_enq), .cq_in(cq_in), .cq_deq(cq_deq),
        .cq_out(cq_out), .cq_ready(cq_ready), .cq_empty(cq_empty), .cq_full(cq_full),
        .cq_overflow_cnt(cq_overflow_cnt)
    );

    typedef struct {
        logic [63:0] d;
        int          t;
    } ment_t;

    ment_t       mq[$];
    logic [63:0] sb[$];
    int          cyc = 0;
    int          movf = 0;
    bit          known = 0;
    bit          ev = 0;
    logic        e_ready, e_empty, e_full;
    logic [63:0] e_out;
    logic [15:0] e_ovf;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // model: an entry may leave once DL edges have passed since the edge that pushed it
    task automatic step(bit r, bit en, bit dq, logic [63:0] d);
        bit p;
        @(negedge clk);
        ev      = known;
        e_ready = 1'b0;
        if (mq.size() > 0) e_ready = (cyc - mq[0].t) >= DL;
        e_out   = e_ready ? mq[0].d : 64'h0;
        e_empty = mq.size() == 0;
        e_full  = mq.size() == D;
        e_ovf   = 16'(movf);
        rst = r; cq_enq = en; cq_deq = dq; cq_in = d;
        p = !r && dq && e_ready;
        if (r) begin
            mq.delete();
            movf  = 0;
            known = 1;
        end else begin
            if (p) begin
                sb.push_back(mq[0].d);
                void'(mq.pop_front());
            end
            if (en) begin
                if (mq.size() == D) begin
                    void'(mq.pop_front());
                    if (movf < 65535) movf++;
                end
                mq.push_back('{d, cyc});
            end
        end
        cyc++;
    endtask

    // monitor: status every cycle, popped data against the scoreboard
    initial forever begin
        @(negedge clk);
        #2;
        if (ev) begin
            chk("ready", 64'(cq_ready), 64'(e_ready));
            chk("out", cq_out, e_out);
            chk("empty", 64'(cq_empty), 64'(e_empty));
            chk("full", 64'(cq_full), 64'(e_full));
            chk("ovf", 64'(cq_overflow_cnt), 64'(e_ovf));
            if (cq_ready && cq_deq && !rst) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_unexpected cycle=%0d got=%h expected=none", cyc, cq_out);
                end else chk("pop_data", cq_out, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; cq_enq = 1'b0; cq_deq = 1'b0; cq_in = '0;
        repeat (3) step(1, 0, 0, 0);
        repeat (100) step(0, 0, 1'($urandom_range(0, 1)), 0);
        step(0, 1, 1, 64'hABC);
        repeat (80) step(0, 0, 1, 0);
        for (int i = 1; i <= 16; i++) step(0, 1, 0, 64'(i));
        repeat (90) step(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, {$urandom, $urandom});
        repeat (70) step(0, 0, 0, 0);
        step(0, 1, 1, 64'h55);
        repeat (90) step(0, 0, 1, 0);
        step(0, 1, 0, 64'h7);
        repeat (5000) step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (3) step(0, 1, 0, {$urandom, $urandom});
        repeat (25) step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        repeat (100) step(0, 0, 1, 0);
        repeat (3000) step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 2) == 0),
                           1'($urandom_range(0, 1)), {$urandom, $urandom});
        repeat (2) step(0, 0, 0, 0);
        #5;
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bop_delay_queue.md
Name: bop_delay_queue

Overview:
- Timed circular FIFO: the responder end of the best-offset prefetcher's delay-queue (cq_*) interface.
- Holds base-address tags that the prefetcher pushes on each prefetch decision. Releases each tag only after it has aged DELAY cycles; the prefetcher then inserts the tag into the left recent-requests bank.
- Models the fill latency of a prefetch. Sits beside the prefetcher in the prefetcher subsystem, one instance per prefetcher.

Parameters:
- WIDTH, 64, width of cq_in / cq_out data.
- DEPTH, 15, number of entries (DELAYQSIZE).
- DELAY, 60, minimum age in cycles before an entry may leave; must satisfy 1 <= DELAY < 2**TIME_BITS.
- TIME_BITS, 12, width of the free-running timestamp counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cq_enq  in  1  push request, sampled at posedge.
- cq_in  in  WIDTH  data to push.
- cq_deq  in  1  pop request; honoured only when cq_ready=1 (prefetcher ties it high).
- cq_out  out  WIDTH  head entry data; valid when cq_ready=1, else 0.
- cq_ready  out  1  head entry present and matured.
- cq_empty  out  1  occupancy == 0.
- cq_full  out  1  occupancy == DEPTH.
- cq_overflow_cnt  out  16  saturating count of entries dropped on push-when-full.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state: head=0, tail=0, count=0, time=0, all valid and matured bits 0, cq_overflow_cnt=0.
- Output values in reset and just after: cq_empty=1, cq_full=0, cq_ready=0, cq_out=0.
- A reset asserted mid-operation discards all entries on that edge; no pending pop is honoured.
- Timestamp counter: time increments by 1 every non-reset cycle and wraps modulo 2**TIME_BITS.
- Entry layout: {data[WIDTH], ts[TIME_BITS], matured}.
- Push (cq_enq=1 at edge t):
  - writes {cq_in, time, 0} at tail;
  - tail advances modulo DEPTH (DEPTH-1 wraps to 0);
  - count increments, unless a pop or drop happens in the same cycle (see below).
- Age of the head entry: age = (time - ts[head]) mod 2**TIME_BITS, unsigned TIME_BITS-bit subtraction.
- Matured flag: each cycle, every valid entry with age >= DELAY sets matured=1, sticky. This prevents re-aliasing after counter wrap for entries older than 2**TIME_BITS.
- Readiness (combinational from registered state): cq_ready = (count != 0) & (matured[head] | age(head) >= DELAY).
- Release latency:
  - An entry pushed at edge t reports ready in the cycle after edge t+DELAY-1, i.e. exactly DELAY cycles after push.
  - The earliest pop is at edge t+DELAY.
- cq_out = data[head] when cq_ready, else 0.
- Pop (cq_deq & cq_ready at edge):
  - clears the head valid bit;
  - head advances modulo DEPTH;
  - count decrements.
- cq_deq while not ready: ignored, no state change.
- Push and pop in the same edge: both take effect and count is unchanged. Legal at any occupancy, including full.
- Push when full with no pop that edge (oldest-drop policy):
  - the head entry is discarded and head advances;
  - the new entry is written at tail and tail advances;
  - count stays DEPTH;
  - cq_overflow_cnt increments, saturating at 16'hFFFF.
- Push when empty and DELAY cycles not elapsed: entry is stored and cq_ready stays 0.
- Ordering is strict FIFO: a younger entry never leaves before an older one, even if both are matured.
- No X on outputs after reset; unused slots hold their stale data, which is not observable.

Decomposition:
- Package bop_pkg holds shared constants and types:
  - DELAYQSIZE=15, DELAY=60, TIME_BITS=12, LOGLINE=6, NOFFSETS=46;
  - typedef bop_dq_entry_t {data, ts, matured};
  - typedef for the timestamp.
- The prefetcher later imports the same package.
- No sub-module is required. Pointer wrap and count logic stay inline; the entry array is a register array of bop_dq_entry_t[DEPTH].

Test Plan:
- Reset then idle 100 cycles -> cq_empty=1, cq_ready=0, cq_out=0, cq_full=0 throughout.
- Push 0xABC at edge 10 with cq_deq=1 held -> cq_ready first 1 in the cycle after edge 69. Pop at edge 70 shows cq_out=0xABC; cq_empty=1 afterwards.
- Push 15 entries 0x1..0xF on consecutive edges, no pop -> cq_full=1. A 16th push of 0x10 leaves cq_full=1 and cq_overflow_cnt=1. Draining yields 0x2..0x10 in order, each no earlier than 60 cycles after its own push.
- Full queue with head matured; push 0x55 and pop on the same edge -> count stays 15, popped value is the old head, cq_overflow_cnt unchanged, 0x55 placed at tail.
- Push 0x7 with cq_deq=0 held for 5000 cycles (time wraps past 4096) -> cq_ready stays 1 from cycle 60 onward; a later pop returns 0x7.
- Push 3 entries, then assert rst for one edge at cycle 30 -> next cycle count=0, cq_empty=1. No stale entry ever reaches cq_ready.
